mips_regfile: RTL and testbench
===============================

Name: mips_regfile

Overview:
- General-purpose register file of the single-cycle MIPS datapath.
- Sits directly upstream of the ALU operand mux: rd2 feeds the register-vs-immediate 2:1 mux, rd1 feeds the ALU A input.
- Consumes the 5-bit destination-select mux output (rt/rd) as write address and the 32-bit write-back mux output as write data.
- Adds a sequential debug dump engine that streams all registers out, one per cycle, under a 4-phase handshake.

Parameters:
- W, 32, data width in bits.
- AW, 5, address width; register count N = 2**AW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ra1  in  AW  read address, port 1.
- ra2  in  AW  read address, port 2.
- rd1  out  W  read data, port 1 (combinational).
- rd2  out  W  read data, port 2 (combinational).
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  W  write data.
- dump_req  in  1  dump request, level (4-phase handshake).
- dump_valid  out  1  dump_addr/dump_data valid this cycle.
- dump_addr  out  AW  register index being dumped.
- dump_data  out  W  contents of register dump_addr.
- dump_done  out  1  dump complete; held until dump_req drops.

Behaviour:
- Storage: N registers of W bits. Register 0 reads as 0 always; writes to it are ignored.
- Reset: with rst=1 at a rising edge, all registers clear to 0 and the FSM goes to IDLE. Reset dominates any same-cycle write.
- Output values after reset: dump_valid=0, dump_addr=0, dump_done=0, dump_data=0, rd1=rd2=0.
- Read: rd1=R[ra1], rd2=R[ra2]. Purely combinational, zero latency.
- Write: at a rising edge with we=1, rst=0 and wa!=0, R[wa]<=wd. The value is visible on the read ports the following cycle.
- Same-cycle read of wa returns the old value unless the optional feature is enabled.
- Dump FSM states: IDLE, DUMP, DONE. ptr is an AW-bit counter.
- IDLE: dump_valid=0, dump_done=0. If dump_req=1 at an edge, go to DUMP with ptr=0.
- DUMP:
  - dump_valid=1, dump_addr=ptr, dump_data=R[ptr] combinationally (register 0 gives 0).
  - ptr increments each edge.
  - When ptr==N-1 at an edge, go to DONE (no wrap to 0 inside DUMP).
  - Exactly N valid cycles per dump.
- dump_req deasserting during DUMP does not abort; the dump runs to completion.
- DONE: dump_valid=0, dump_done=1. Stays until dump_req=0 at an edge, then returns to IDLE. A new dump requires dump_req low, then high.
- Writes during DUMP:
  - Allowed; the register write path is never stalled.
  - A write to the register being dumped in the same cycle shows the old value on dump_data.
  - A write to a not-yet-dumped register shows the new value when that register is reached.
- Reset mid-dump: FSM returns to IDLE next edge, ptr=0, all dump outputs 0, registers cleared.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding on rd1/rd2 only. If we=1 and wa!=0 and ra1==wa, then rd1=wd (same for rd2). dump_data is never bypassed.
- Undefined: read ports always show stored contents; the new value appears the cycle after the write edge.

Test Plan:
- Reset check: assert rst for 1 cycle, then read all 32 addresses on both ports -> every value 0; dump_valid=0, dump_done=0.
- Basic write/read: write R5=55 and R7=30 on consecutive cycles, then ra1=5, ra2=7 -> rd1=55, rd2=30. Write R0=0xFFFFFFFF -> ra1=0 reads 0.
- Same-cycle hazard: R5=55, then we=1, wa=5, wd=99 with ra1=5.
  - Without macro: rd1=55 before the edge, 99 after.
  - With macro: rd1=99 before the edge.
- Full dump: preload Rk=k*3 for k=1..31, then raise dump_req.
  - Exactly 32 dump_valid cycles, addr 0..31, data 0,3,...,93.
  - dump_done=1 until dump_req drops, then dump_done=0 one edge later.
- Write during dump and reset mid-dump:
  - While dumping, when dump_addr=10, write R20=0xABCD -> the addr-20 beat shows 0xABCD.
  - Assert rst at addr=15 -> next cycle dump_valid=0, dump_addr=0, rd1=0 for all addresses.

Source files
------------

// File: rtl/mips_regfile.sv
// mips_regfile
//   General-purpose register file for the single-cycle MIPS datapath, with a
//   sequential debug dump engine that streams every register out, one per
//   cycle, under a 4-phase request/done handshake.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset (clears registers, FSM to IDLE)
//     ra1, ra2   combinational read addresses; rd1, rd2 read data
//     we, wa, wd write enable / address / data (writes to register 0 dropped)
//     dump_req   level request; dump starts when high in IDLE
//     dump_valid dump_addr/dump_data carry a register this cycle
//     dump_addr  index being dumped
//     dump_data  contents of register dump_addr
//     dump_done  dump finished; held until dump_req drops
//
//   Build option:
//     REGFILE_BYPASS_EN  when defined, rd1/rd2 forward same-cycle write data.
//                        dump_data is never forwarded.
//
//   state | meaning
//   IDLE  | waiting for dump_req
//   DUMP  | streaming register ptr, one per cycle, 0 .. N-1
//   DONE  | dump finished, dump_done high until dump_req drops

module mips_regfile #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          dump_req,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [W-1:0]  dump_data,
  output logic          dump_done
);

  localparam int N = 2 ** AW;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [W-1:0] mem [N];

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // Register 0 is hard-wired to zero regardless of array contents.
  function automatic logic [W-1:0] read_reg(input logic [AW-1:0] a);
    return (a == '0) ? '0 : mem[a];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign rd1 = (we && (wa != '0) && (ra1 == wa)) ? wd : read_reg(ra1);
  assign rd2 = (we && (wa != '0) && (ra2 == wa)) ? wd : read_reg(ra2);
`else
  assign rd1 = read_reg(ra1);
  assign rd2 = read_reg(ra2);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dump_valid = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    dump_done  = 1'b0;
    case (state_q)
      IDLE: begin
        ptr_d = '0;
        if (dump_req) begin
          state_d = DUMP;
        end
      end
      DUMP: begin
        dump_valid = 1'b1;
        dump_addr  = ptr_q;
        dump_data  = read_reg(ptr_q);
        // Stop at the last index instead of wrapping so exactly N beats go out;
        // dump_req is ignored here so a dropped request never aborts.
        if (ptr_q == LAST) begin
          state_d = DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      DONE: begin
        dump_done = 1'b1;
        if (!dump_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_regfile.sv
module tb_mips_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, wa, dump_addr;
  logic [31:0] rd1, rd2, wd, dump_data;
  logic        we, dump_req, dump_valid, dump_done;

  int n_checks = 0;
  int n_fail   = 0;

  mips_regfile #(.W(32), .AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    step();
    we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      check({tag, "_rd1"}, rd1, 32'd0);
      check({tag, "_rd2"}, rd2, 32'd0);
    end
  endtask

  initial begin
    int cnt;
    logic [31:0] exp;

    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dump_req = 1'b0;
    step();
    rst = 1'b0;
    check_all_zero("reset");
    check("reset_valid", {31'd0, dump_valid}, 32'd0);
    check("reset_done", {31'd0, dump_done}, 32'd0);
    check("reset_addr", {27'd0, dump_addr}, 32'd0);
    check("reset_data", dump_data, 32'd0);

    write_reg(5'd5, 32'd55);
    write_reg(5'd7, 32'd30);
    ra1 = 5'd5; ra2 = 5'd7; #1;
    check("rd1_r5", rd1, 32'd55);
    check("rd2_r7", rd2, 32'd30);
    write_reg(5'd0, 32'hFFFF_FFFF);
    ra1 = 5'd0; #1;
    check("r0_zero", rd1, 32'd0);

    // Same-cycle write/read hazard on R5
    ra1 = 5'd5;
    we = 1'b1; wa = 5'd5; wd = 32'd99;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("hazard_before", rd1, 32'd99);
`else
    check("hazard_before", rd1, 32'd55);
`endif
    step();
    we = 1'b0;
    check("hazard_after", rd1, 32'd99);

    for (int k = 1; k < 32; k++) write_reg(5'(k), 32'(k * 3));

    // Dump 1: full stream, request held until done
    dump_req = 1'b1;
    step();
    cnt = 0;
    for (int cyc = 0; cyc < 40 && !dump_done; cyc++) begin
      check("d1_valid", {31'd0, dump_valid}, 32'd1);
      check("d1_addr", {27'd0, dump_addr}, 32'(cnt));
      check("d1_data", dump_data, 32'(cnt * 3));
      cnt++;
      step();
    end
    check("d1_beats", 32'(cnt), 32'd32);
    check("d1_done", {31'd0, dump_done}, 32'd1);
    check("d1_valid_off", {31'd0, dump_valid}, 32'd0);
    step();
    check("d1_done_held", {31'd0, dump_done}, 32'd1);
    step();
    check("d1_done_held2", {31'd0, dump_done}, 32'd1);
    dump_req = 1'b0;
    step();
    check("d1_done_drop", {31'd0, dump_done}, 32'd0);
    check("d1_idle_valid", {31'd0, dump_valid}, 32'd0);

    // Dump 2: request dropped early, writes while streaming
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 40 && !dump_done; cyc++) begin
      exp = (cnt == 20) ? 32'h0000_ABCD : 32'(cnt * 3);
      check("d2_addr", {27'd0, dump_addr}, 32'(cnt));
      check("d2_data", dump_data, exp);
      if (dump_addr == 5'd10) begin
        we = 1'b1; wa = 5'd20; wd = 32'h0000_ABCD;
      end else if (dump_addr == 5'd12) begin
        we = 1'b1; wa = 5'd12; wd = 32'h0000_1234;
        #1;
        check("d2_same_reg_old", dump_data, 32'd36);
      end else begin
        we = 1'b0;
      end
      cnt++;
      step();
    end
    we = 1'b0;
    check("d2_beats", 32'(cnt), 32'd32);
    check("d2_done", {31'd0, dump_done}, 32'd1);
    step();
    check("d2_back_idle", {31'd0, dump_done}, 32'd0);

    // Dump 3: reset at addr 15
    dump_req = 1'b1;
    step();
    cnt = 0;
    for (int cyc = 0; cyc < 40 && dump_addr != 5'd15; cyc++) begin
      exp = (cnt == 12) ? 32'h0000_1234 : 32'(cnt * 3);
      check("d3_data", dump_data, exp);
      cnt++;
      step();
    end
    check("d3_reach15", {27'd0, dump_addr}, 32'd15);
    rst = 1'b1;
    step();
    rst = 1'b0;
    dump_req = 1'b0;
    check("rst_mid_valid", {31'd0, dump_valid}, 32'd0);
    check("rst_mid_addr", {27'd0, dump_addr}, 32'd0);
    check("rst_mid_data", dump_data, 32'd0);
    check("rst_mid_done", {31'd0, dump_done}, 32'd0);
    check_all_zero("rst_mid");
    step();
    check("rst_mid_stay_idle", {31'd0, dump_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
